// File: rtl/nic_tx_queue_if.sv
// nic_tx_queue_if: CPU write path, status and router PE-port signals of the
// NIC transmit queue. The queue takes the slave side; the NIC/router
// environment takes the master side.
interface nic_tx_queue_if #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // CPU-side write path and queue control
  logic                    flush;
  logic                    wr_en;
  logic [PACKET_WIDTH-1:0] wr_data;

  // Status back to the NIC status register
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic                    overflow;

  // Router PE input port (peri / polarity_out / pesi / pedi)
  logic                    net_ri;
  logic                    net_polarity;
  logic                    net_so;
  logic [PACKET_WIDTH-1:0] net_do;

  modport master (
    output flush, wr_en, wr_data, net_ri, net_polarity,
    input  full, empty, count, overflow, net_so, net_do
  );

  modport slave (
    input  flush, wr_en, wr_data, net_ri, net_polarity,
    output full, empty, count, overflow, net_so, net_do
  );
endinterface

// File: rtl/nic_tx_queue.sv
// nic_tx_queue: circular transmit queue between the NIC output channel and a
// router PE input port. The head packet launches only when the router is
// ready and the current polarity phase differs from the packet's VC bit
// (MSB). Strict FIFO order; an ineligible head blocks everything behind it.
// Optional feature macro: NIC_TXQ_STATS_EN adds the tx_count launch counter.
module nic_tx_queue #(
  parameter int PACKET_WIDTH = 64,
  parameter int DEPTH        = 4
) (
  input  logic              clk,
  input  logic              reset,
  nic_tx_queue_if.slave     q
`ifdef NIC_TXQ_STATS_EN
  ,
  output logic [15:0]       tx_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_nxt;
  logic                    full_q;
  logic                    empty_q;
  logic                    overflow_q;
  logic                    so_q;
  logic [PACKET_WIDTH-1:0] do_q;

  logic [PACKET_WIDTH-1:0] head;
  logic                    launch;
  logic                    accept;
  logic                    drop;

  // Head eligibility, write acceptance and next occupancy
  always_comb begin
    head      = mem[rd_ptr];
    launch    = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;
    count_nxt = count_q;
    if (count_q != '0 && q.net_ri && (head[PACKET_WIDTH-1] != q.net_polarity)) begin
      launch = 1'b1;
    end
    // A full queue still takes a write when the head leaves on the same edge.
    if (q.wr_en) begin
      if (count_q != CW'(DEPTH) || launch) begin
        accept = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    case ({accept, launch})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointers, occupancy, status flags and the registered router outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      so_q       <= 1'b0;
      do_q       <= '0;
    end else if (q.flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      so_q       <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (launch) begin
        rd_ptr <= rd_ptr + AW'(1);
        do_q   <= head;
      end
      so_q    <= launch;
      count_q <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Packet storage; stale contents are harmless because occupancy gates reads
  always_ff @(posedge clk) begin
    if (!q.flush && accept) begin
      mem[wr_ptr] <= q.wr_data;
    end
  end

`ifdef NIC_TXQ_STATS_EN
  // Launched-packet counter, wraps at 16 bits and survives flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count <= '0;
    end else if (!q.flush && launch) begin
      tx_count <= tx_count + 16'd1;
    end
  end
`endif

  assign q.full     = full_q;
  assign q.empty    = empty_q;
  assign q.count    = count_q;
  assign q.overflow = overflow_q;
  assign q.net_so   = so_q;
  assign q.net_do   = do_q;

endmodule

// File: tb/tb_nic_tx_queue.sv
// tb_nic_tx_queue: randomized and directed stimulus against a queue-based
// reference model; launched packets go through an expected-packet scoreboard
// popped by a separate negedge monitor.
module tb_nic_tx_queue;
  localparam int PW    = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  nic_tx_queue_if #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) bus ();

`ifdef NIC_TXQ_STATS_EN
  logic [15:0] tx_count;
`endif

  nic_tx_queue #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
`ifdef NIC_TXQ_STATS_EN
    ,
    .tx_count (tx_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a plain packet queue updated once per rising edge
  logic [PW-1:0] mq[$];
  logic [PW-1:0] expq[$];
  bit            m_so;
  logic [PW-1:0] m_do;
  bit            m_ovf;
  logic [15:0]   m_txc;
  int unsigned   m_launches;
  int            m_pre;
  bit            m_l;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      expq.delete();
      m_so  = 1'b0;
      m_do  = '0;
      m_ovf = 1'b0;
      m_txc = '0;
    end else if (bus.flush) begin
      mq.delete();
      expq.delete();
      m_so  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      m_pre = mq.size();
      m_l   = 1'b0;
      if (m_pre > 0 && bus.net_ri && (mq[0][PW-1] != bus.net_polarity)) m_l = 1'b1;
      m_so = m_l;
      if (m_l) begin
        m_do = mq.pop_front();
        expq.push_back(m_do);
        m_txc = m_txc + 16'd1;
        m_launches++;
      end
      if (bus.wr_en) begin
        if (m_pre < DEPTH || m_l) mq.push_back(bus.wr_data);
        else m_ovf = 1'b1;
      end
    end
  end

  // Monitor: pop the scoreboard on every launch, check status each cycle
  logic [PW-1:0] e_pkt;
  always @(negedge clk) begin
    chk("net_so", {63'd0, bus.net_so}, {63'd0, m_so});
    if (m_so) begin
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: launch with no expected packet at %0t", $time);
      end else begin
        e_pkt = expq.pop_front();
        chk("pkt_order", bus.net_do, e_pkt);
      end
    end
    chk("net_do",   bus.net_do, m_do);
    chk("count",    64'(bus.count), 64'(mq.size()));
    chk("full",     {63'd0, bus.full},  {63'd0, mq.size() == DEPTH});
    chk("empty",    {63'd0, bus.empty}, {63'd0, mq.size() == 0});
    chk("overflow", {63'd0, bus.overflow}, {63'd0, m_ovf});
`ifdef NIC_TXQ_STATS_EN
    chk("tx_count", 64'(tx_count), 64'(m_txc));
`endif
  end

  // One clock: edge, then polarity flips for the following edge
  task automatic step();
    @(posedge clk);
    #1;
    bus.net_polarity = ~bus.net_polarity;
  endtask

  task automatic write(input logic [PW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    int p;
    int w;
    int run;
    logic [PW-1:0] last;

    reset            = 1'b1;
    bus.flush        = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_data      = '0;
    bus.net_ri       = 1'b0;
    bus.net_polarity = 1'b0;
    step();
    step();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_empty", {63'd0, bus.empty}, 64'd1);
    chk("rst_so",    {63'd0, bus.net_so}, 64'd0);
    chk("rst_do",    bus.net_do, 64'd0);
    reset = 1'b0;

    // Single VC0 packet
    bus.net_ri = 1'b1;
    write(64'h0000_0000_0000_00A5);
    p    = 0;
    last = '0;
    repeat (4) begin
      if (bus.net_so) begin
        p++;
        last = bus.net_do;
      end
      step();
    end
    chk("single_pulses", 64'(p), 64'd1);
    chk("single_data",   last, 64'h0000_0000_0000_00A5);
    chk("single_count",  64'(bus.count), 64'd0);

    // Overfill while the router is not ready
    bus.net_ri = 1'b0;
    for (int i = 0; i < 5; i++) write(64'h1000 + 64'(i));
    chk("ovf_count", 64'(bus.count), 64'd4);
    chk("ovf_full",  {63'd0, bus.full}, 64'd1);
    chk("ovf_flag",  {63'd0, bus.overflow}, 64'd1);
    bus.net_ri = 1'b1;
    repeat (12) step();
    chk("ovf_drain", 64'(bus.count), 64'd0);
    chk("ovf_sticky", {63'd0, bus.overflow}, 64'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("ovf_clear", {63'd0, bus.overflow}, 64'd0);

    // Alternating VCs: four launches back to back
    bus.net_ri = 1'b0;
    for (int i = 0; i < 4; i++) write({i[0], 63'h2000 + 63'(i)});
    bus.net_ri = 1'b1;
    w = 0;
    while (!bus.net_so && w < 6) begin
      step();
      w++;
    end
    run = 0;
    while (bus.net_so && run < 8) begin
      run++;
      step();
    end
    chk("alt_run", 64'(run), 64'd4);

    // Full queue, write and launch on the same edge
    bus.net_ri = 1'b0;
    for (int i = 0; i < 4; i++) write(64'h3000 + 64'(i));
    if (bus.net_polarity != 1'b1) step();
    bus.net_ri  = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 64'h3004;
    step();
    bus.wr_en  = 1'b0;
    bus.net_ri = 1'b0;
    chk("fullwr_count", 64'(bus.count), 64'd4);
    chk("fullwr_ovf",   {63'd0, bus.overflow}, 64'd0);
    chk("fullwr_so",    {63'd0, bus.net_so}, 64'd1);
    bus.net_ri = 1'b1;
    repeat (10) step();

    // Flush with three queued and the router ready
    bus.net_ri = 1'b0;
    for (int i = 0; i < 3; i++) write({1'b1, 63'h4000 + 63'(i)});
    bus.flush  = 1'b1;
    bus.net_ri = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_empty", {63'd0, bus.empty}, 64'd1);
    chk("flush_so",    {63'd0, bus.net_so}, 64'd0);
    chk("flush_ovf",   {63'd0, bus.overflow}, 64'd0);
    write(64'h5000);
    repeat (4) step();
    chk("flush_after", 64'(bus.count), 64'd0);

    // Asynchronous reset between edges with two queued
    bus.net_ri = 1'b0;
    write(64'h6000);
    write(64'h6001);
    chk("arst_pre", 64'(bus.count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_empty", {63'd0, bus.empty}, 64'd1);
    chk("arst_so",    {63'd0, bus.net_so}, 64'd0);
    chk("arst_do",    bus.net_do, 64'd0);
    step();
    reset = 1'b0;

    // Randomized traffic
    repeat (3000) begin
      bus.wr_en   = ($urandom_range(0, 99) < 60);
      bus.wr_data = {$urandom, $urandom};
      bus.net_ri  = ($urandom_range(0, 99) < 70);
      bus.flush   = ($urandom_range(0, 99) == 0);
      step();
    end
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;

`ifdef NIC_TXQ_STATS_EN
    // Long VC-alternating stream to carry tx_count through its wrap
    bus.net_ri = 1'b1;
    repeat (70000) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = {~bus.net_polarity, 31'd0, 32'($urandom)};
      step();
    end
    bus.wr_en = 1'b0;
    repeat (8) step();
    chk("txc_wrap", 64'(tx_count), 64'(m_launches[15:0]));
`endif

    bus.net_ri = 1'b1;
    repeat (8) step();
    chk("final_count", 64'(bus.count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nic_tx_queue.md
# nic_tx_queue

Transmit-side packet queue placed between the CPU-facing NIC output-channel write path and a router's PE input port (pesi/pedi/peri) in each mesh node. It buffers up to DEPTH 64-bit packets written by the CPU side. It launches one packet per eligible cycle into the router, and only in the router polarity phase matching the packet's virtual-channel bit. It also reports occupancy and overflow status back to the NIC status register.

## Interface
- PACKET_WIDTH, 64, packet width in bits; bit PACKET_WIDTH-1 is the VC bit.
- DEPTH, 4, queue entries; power of two, at least 2.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- flush  input  1  synchronous queue clear.
- wr_en  input  1  write strobe from NIC output-channel write.
- wr_data  input  PACKET_WIDTH  packet to enqueue.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- count  output  log2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when a write is dropped.
- net_ri  input  1  router PE input buffer ready (peri).
- net_polarity  input  1  router polarity_out; toggles every cycle.
- net_so  output  1  send strobe to router pesi.
- net_do  output  PACKET_WIDTH  packet to router pedi.
- tx_count  output  16  launched-packet counter; present only under NIC_TXQ_STATS_EN.

## Operation
- Circular buffer with read pointer, write pointer, and occupancy counter. Pointers wrap modulo DEPTH.
- Head eligibility is decided at each rising edge:
  - queue non-empty, and
  - net_ri == 1, and
  - head[PACKET_WIDTH-1] != net_polarity.
- When the head is eligible:
  - the head is loaded into the net_do register and net_so is set to 1 for that cycle;
  - the head is popped.
- When the head is not eligible, net_so is 0 and net_do holds its last value.
- Writes:
  - wr_en with count < DEPTH: enqueue at the write pointer.
  - wr_en with count == DEPTH and no same-edge pop: write dropped, overflow set.
  - wr_en with count == DEPTH and a same-edge pop: write accepted, count stays DEPTH.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- Write to an empty queue: the packet is not eligible on the same edge. It can launch from the next edge at the earliest.
- Ordering is strictly FIFO. There is no VC reordering; an ineligible head blocks the entries behind it.
- flush (takes priority over wr_en and launch):
  - pointers and count go to 0;
  - net_so goes to 0;
  - overflow is cleared;
  - tx_count is not affected.
- overflow is cleared only by reset or flush.

## Timing
- Reset values: net_so=0, net_do=0, count=0, empty=1, full=0, overflow=0, tx_count=0, both pointers 0.
- Reset asserted mid-operation: all queued packets are discarded immediately and asynchronously.
- net_so and net_do are registered. net_so is high for exactly one cycle per packet, and the router samples them on the following edge.
- Minimum write-to-launch latency is 1 cycle, i.e. net_so is visible in cycle N+1 for a write at edge N. This requires net_ri=1 and matching polarity at edge N+1; otherwise the packet waits for the next matching phase, at most 1 extra cycle while net_ri stays high.
- Steady-state throughput: one packet every 2 cycles for a single VC; one packet per cycle for alternating VCs.
- full, empty, and count are registered and reflect the state after each edge.
- net_polarity and net_ri are sampled only at the rising edge; there are no combinational paths from inputs to outputs.

## Configuration
- NIC_TXQ_STATS_EN defined:
  - the tx_count port exists;
  - it increments by 1 on every launch and wraps 0xFFFF -> 0x0000;
  - it is cleared only by reset.
- NIC_TXQ_STATS_EN undefined: the tx_count port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then 1 write of 0x0000_0000_0000_00A5 (VC0) with net_ri=1 -> net_so pulses once, on the first edge after the write where net_polarity=1; net_do=0x...A5; count returns to 0.
- 5 back-to-back writes with net_ri=0 -> count=4, full=1, overflow=1; the 5th packet is lost. Then net_ri=1 -> exactly 4 packets emerge in order.
- Alternating VC0/VC1 packets, queue pre-filled with 4, net_ri=1 -> one launch per cycle, 4 consecutive net_so cycles, order preserved.
- Queue full, with a write and a launch on the same edge -> write accepted, count stays 4, overflow stays 0.
- flush while 3 packets are queued and net_ri=1 -> next cycle count=0, empty=1, net_so=0, overflow=0; a subsequent write launches normally.
- Reset asserted asynchronously between edges while 2 packets are queued -> outputs go to their reset values before the next edge. With NIC_TXQ_STATS_EN, 65536 launches -> tx_count wraps to 0.
